int_rf_wr_arbiter: RTL and testbench
====================================

Name: int_rf_wr_arbiter

Overview:
- Shares the single write port of the integer register file among NUM_REQ commit-side requesters (e.g. integer commit, load commit, CSR-read commit).
- Each requester owns a 1-entry write buffer (slot). A round-robin arbiter drains one slot per cycle into the RF write port.
- Exposes a bypass/hazard lookup so issue can see values still buffered and not yet written.

Parameters:
- NUM_REQ, 3, number of write requesters (≥2).
- XLEN, len5_pkg::XLEN, data width.
- REG_IDX_LEN, len5_pkg::REG_IDX_LEN, register index width.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester write request valid.
- req_ready_o  out  NUM_REQ  per-requester ready.
- req_rd_idx_i  in  NUM_REQ x REG_IDX_LEN  destination index per requester.
- req_rd_value_i  in  NUM_REQ x XLEN  write data per requester.
- rf_valid_o  out  1  write enable to the RF write port.
- rf_rd_idx_o  out  REG_IDX_LEN  RF write index.
- rf_rd_value_o  out  XLEN  RF write data.
- chk_idx_i  in  2 x REG_IDX_LEN  lookup indices (rs1, rs2) from issue.
- chk_hit_o  out  2  a buffered write targets chk_idx_i[k].
- chk_value_o  out  2 x XLEN  buffered value for a hit; '0 otherwise.

Behaviour:
- Reset:
  - all slots empty; rr pointer = 0.
  - rf_valid_o = 0; rf_rd_idx_o = 0; rf_rd_value_o = 0.
  - chk_hit_o = 0; req_ready_o = all ones.
- Slot state per requester i: full bit, idx, value. All flip-flops.
- Arbitration (combinational from slot state only):
  - grant = first full slot scanning i = ptr, ptr+1, … mod NUM_REQ.
  - No full slot → no grant.
- RF outputs:
  - rf_valid_o = any slot full.
  - rf_rd_idx_o / rf_rd_value_o = granted slot's contents; 0 when no grant.
- Pointer: on grant g, ptr <= (g+1) mod NUM_REQ. Unchanged when there is no grant.
- Ready: req_ready_o[i] = ~full[i] | grant[i]. It never depends on req_valid_i, so there is no valid→ready combinational path.
- Accept (req_valid_i[i] & req_ready_o[i]):
  - rd_idx ≠ 0: slot loads idx/value and full <= 1.
  - rd_idx == 0: request is consumed (ready seen) but not buffered, and never reaches the RF.
- Grant and accept on the same slot in the same cycle: the slot stays full with the new data, giving back-to-back throughput of 1 write/cycle per requester when uncontended.
- Grant with no new accept: full <= 0.
- Latency: accept in cycle N → rf_valid_o earliest in cycle N+1 (one cycle from a registered slot).
- Worst-case wait for a full slot before it is granted: NUM_REQ-1 cycles (starvation-free).
- Lookup:
  - chk_hit_o[k] = 1 iff chk_idx_i[k] ≠ 0 and some full slot has idx == chk_idx_i[k].
  - chk_value_o[k] = that slot's value. This is purely combinational.
  - A slot being granted this cycle still reports a hit: the RF updates at the clock edge, so issue must take the bypass value this cycle.
- Ordering rule, upstream contract: at most one full slot may target a given nonzero index at any time. Violation is an assertion failure (simulation only). The block does not reorder.
- Reset mid-operation: all buffered writes are discarded, nothing is written to the RF, and the pointer returns to 0.

Decomposition:
- Add to expipe_pkg:
  - typedef rf_wr_req_t {idx, value}.
  - localparam WR_REQ_NUM = 3.
- Sub-module rr_arbiter (NUM_REQ param):
  - inputs: request vector, enable.
  - outputs: one-hot grant plus grant index.
  - holds the pointer register.
  - reusable for other shared ports.

Test Plan:
- Reset then idle → rf_valid_o=0, req_ready_o=3'b111, chk_hit_o=0.
- Single requester 0: valid 3 consecutive cycles, idx 5/6/7, values 0xA/0xB/0xC → rf writes x5=0xA, x6=0xB, x7=0xC in cycles 1,2,3; ready stays 1.
- All 3 requesters valid in one cycle: idx 1,2,3, values 0x11,0x22,0x33 → RF writes in order req0, req1, req2 over 3 cycles. While pending, each requester's ready = 1 only in the cycle its slot is granted.
- Write to x0 from req1, value 0xFF → ready=1, rf_valid_o never asserts, chk_hit for idx 0 = 0.
- Bypass: req2 buffers x9=0x1234 while req0/req1 slots occupy the arbiter; chk_idx_i[0]=9 → chk_hit_o[0]=1, chk_value_o[0]=0x1234 until the cycle after the x9 write.
- Assert rst_n_i low while 2 slots are full → outputs return to reset values immediately; after release, no stale write appears.

Source files
------------

// File: rtl/int_rf_wr_arbiter_pkg.sv
// Shared types and sizes for the integer register-file write arbiter.
package int_rf_wr_arbiter_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned REG_IDX_LEN = 5;
    localparam int unsigned WR_REQ_NUM  = 3;
    localparam int unsigned NUM_CHK     = 2;

    typedef struct packed {
        logic [REG_IDX_LEN-1:0] idx;
        logic [XLEN-1:0]        value;
    } rf_wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer, pointer moves past the winner.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o
);

    logic [IDX_W-1:0]   ptr_q;
    logic [NUM_REQ-1:0] req_hi;

    // Requests at or above the pointer win over wrapped-around ones.
    always_comb begin
        req_hi      = '0;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = en_i && (|req_i);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_hi[i] = req_i[i] && (i >= 32'(ptr_q));
        end
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_i[i]) gnt_idx_o = IDX_W'(i);
        end
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_hi[i]) gnt_idx_o = IDX_W'(i);
        end
        if (gnt_valid_o) gnt_o[gnt_idx_o] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else if (gnt_valid_o) begin
            ptr_q <= (gnt_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + IDX_W'(1);
        end
    end

endmodule

// File: rtl/int_rf_wr_arbiter.sv
// Shares the integer RF write port among commit-side requesters through 1-entry slots,
// with a bypass lookup over values still buffered.
module int_rf_wr_arbiter
    import int_rf_wr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = WR_REQ_NUM,
    parameter int unsigned XLEN        = int_rf_wr_arbiter_pkg::XLEN,
    parameter int unsigned REG_IDX_LEN = int_rf_wr_arbiter_pkg::REG_IDX_LEN
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic [NUM_REQ-1:0]                    req_valid_i,
    output logic [NUM_REQ-1:0]                    req_ready_o,
    input  logic [NUM_REQ-1:0][REG_IDX_LEN-1:0]   req_rd_idx_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]          req_rd_value_i,
    output logic                                  rf_valid_o,
    output logic [REG_IDX_LEN-1:0]                rf_rd_idx_o,
    output logic [XLEN-1:0]                       rf_rd_value_o,
    input  logic [NUM_CHK-1:0][REG_IDX_LEN-1:0]   chk_idx_i,
    output logic [NUM_CHK-1:0]                    chk_hit_o,
    output logic [NUM_CHK-1:0][XLEN-1:0]          chk_value_o
);

    localparam int unsigned GIDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]                  full_q;
    logic [NUM_REQ-1:0][REG_IDX_LEN-1:0] idx_q;
    logic [NUM_REQ-1:0][XLEN-1:0]        val_q;

    logic [NUM_REQ-1:0] gnt;
    logic [GIDX_W-1:0]  gnt_idx;
    logic               gnt_valid;
    logic               dup_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GIDX_W)
    ) u_rr_arbiter (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .req_i       (full_q),
        .en_i        (1'b1),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // A slot being drained this cycle can take new data, so ready ignores valid.
    assign req_ready_o = ~full_q | gnt;

    // Writes to x0 are consumed but never buffered.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            full_q <= '0;
            idx_q  <= '0;
            val_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_valid_i[i] && req_ready_o[i] && (req_rd_idx_i[i] != '0)) begin
                    full_q[i] <= 1'b1;
                    idx_q[i]  <= req_rd_idx_i[i];
                    val_q[i]  <= req_rd_value_i[i];
                end else if (gnt[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rf_valid_o    = |full_q;
        rf_rd_idx_o   = '0;
        rf_rd_value_o = '0;
        if (gnt_valid) begin
            rf_rd_idx_o   = idx_q[gnt_idx];
            rf_rd_value_o = val_q[gnt_idx];
        end
    end

    // Bypass lookup; a slot granted this cycle still reports its value.
    always_comb begin
        chk_hit_o   = '0;
        chk_value_o = '0;
        for (int unsigned k = 0; k < NUM_CHK; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (full_q[i] && (chk_idx_i[k] != '0) && (idx_q[i] == chk_idx_i[k])) begin
                    chk_hit_o[k]   = 1'b1;
                    chk_value_o[k] = val_q[i];
                end
            end
        end
    end

    always_comb begin
        dup_c = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned j = i + 1; j < NUM_REQ; j++) begin
                if (full_q[i] && full_q[j] && (idx_q[i] == idx_q[j])) dup_c = 1'b1;
            end
        end
    end

    // Upstream must never leave two buffered writes to the same register.
    a_no_dup_idx : assert property (@(posedge clk_i) disable iff (!rst_n_i) !dup_c)
        else $error("int_rf_wr_arbiter: two full slots target the same register");

endmodule

// File: tb/tb_int_rf_wr_arbiter.sv
// Directed bench for int_rf_wr_arbiter: expected RF writes go to a queue checked by a monitor.
module tb_int_rf_wr_arbiter;
    import int_rf_wr_arbiter_pkg::*;

    localparam int unsigned N = WR_REQ_NUM;

    logic                                clk_i = 1'b0;
    logic                                rst_n_i;
    logic [N-1:0]                        req_valid_i;
    logic [N-1:0]                        req_ready_o;
    logic [N-1:0][REG_IDX_LEN-1:0]       req_rd_idx_i;
    logic [N-1:0][XLEN-1:0]              req_rd_value_i;
    logic                                rf_valid_o;
    logic [REG_IDX_LEN-1:0]              rf_rd_idx_o;
    logic [XLEN-1:0]                     rf_rd_value_o;
    logic [NUM_CHK-1:0][REG_IDX_LEN-1:0] chk_idx_i;
    logic [NUM_CHK-1:0]                  chk_hit_o;
    logic [NUM_CHK-1:0][XLEN-1:0]        chk_value_o;

    rf_wr_req_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    int_rf_wr_arbiter dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_rd_idx_i   (req_rd_idx_i),
        .req_rd_value_i (req_rd_value_i),
        .rf_valid_o     (rf_valid_o),
        .rf_rd_idx_o    (rf_rd_idx_o),
        .rf_rd_value_o  (rf_rd_value_o),
        .chk_idx_i      (chk_idx_i),
        .chk_hit_o      (chk_hit_o),
        .chk_value_o    (chk_value_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic push(input logic [REG_IDX_LEN-1:0] idx, input logic [XLEN-1:0] val);
        rf_wr_req_t e;
        e.idx   = idx;
        e.value = val;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int r, input logic [REG_IDX_LEN-1:0] idx, input logic [XLEN-1:0] val);
        req_valid_i[r]    = 1'b1;
        req_rd_idx_i[r]   = idx;
        req_rd_value_i[r] = val;
    endtask

    // Monitor: every RF write must match the oldest expected write.
    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1 && rf_valid_o === 1'b1) begin
            rf_wr_req_t e;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rf_unexpected: got x%0d=0x%0h expected no write at %0t",
                         rf_rd_idx_o, rf_rd_value_o, $time);
            end else begin
                e = exp_q.pop_front();
                chk("rf_idx", 64'(rf_rd_idx_o), 64'(e.idx));
                chk("rf_value", 64'(rf_rd_value_o), 64'(e.value));
            end
        end
    end

    initial begin
        rst_n_i        = 1'b0;
        req_valid_i    = '0;
        req_rd_idx_i   = '0;
        req_rd_value_i = '0;
        chk_idx_i      = '0;

        // Reset state
        cyc(); cyc();
        smp();
        chk("rst_rf_valid", 64'(rf_valid_o), 64'd0);
        chk("rst_ready", 64'(req_ready_o), 64'b111);
        chk("rst_hit", 64'(chk_hit_o), 64'd0);
        chk("rst_rf_idx", 64'(rf_rd_idx_o), 64'd0);
        cyc();
        rst_n_i = 1'b1;
        smp();
        chk("idle_rf_valid", 64'(rf_valid_o), 64'd0);
        chk("idle_ready", 64'(req_ready_o), 64'b111);

        // All three requesters at once, pointer at 0
        cyc();
        drive(0, 5'd1, 64'h11); drive(1, 5'd2, 64'h22); drive(2, 5'd3, 64'h33);
        push(5'd1, 64'h11); push(5'd2, 64'h22); push(5'd3, 64'h33);
        smp(); chk("all3_ready_c0", 64'(req_ready_o), 64'b111);
        cyc(); req_valid_i = '0;
        smp(); chk("all3_ready_c1", 64'(req_ready_o), 64'b001);
        cyc();
        smp(); chk("all3_ready_c2", 64'(req_ready_o), 64'b011);
        cyc();
        smp(); chk("all3_ready_c3", 64'(req_ready_o), 64'b111);
        cyc();
        smp(); chk("all3_drained", 64'(rf_valid_o), 64'd0);

        // Write to x0 is consumed and dropped
        cyc();
        drive(1, 5'd0, 64'hFF);
        chk_idx_i[0] = 5'd0;
        smp();
        chk("x0_ready", 64'(req_ready_o[1]), 64'd1);
        cyc(); req_valid_i = '0;
        smp();
        chk("x0_rf_valid", 64'(rf_valid_o), 64'd0);
        chk("x0_hit", 64'(chk_hit_o[0]), 64'd0);
        cyc();
        smp(); chk("x0_rf_valid2", 64'(rf_valid_o), 64'd0);

        // Bypass of buffered x9 (and x11) until written
        cyc();
        drive(0, 5'd10, 64'h100); drive(1, 5'd11, 64'h200); drive(2, 5'd9, 64'h1234);
        push(5'd10, 64'h100); push(5'd11, 64'h200); push(5'd9, 64'h1234);
        chk_idx_i[0] = 5'd9;
        chk_idx_i[1] = 5'd11;
        smp(); chk("byp_hit_c0", 64'(chk_hit_o), 64'b00);
        cyc(); req_valid_i = '0;
        smp();
        chk("byp_hit_c1", 64'(chk_hit_o), 64'b11);
        chk("byp_val0_c1", chk_value_o[0], 64'h1234);
        chk("byp_val1_c1", chk_value_o[1], 64'h200);
        cyc();
        smp();
        chk("byp_hit_c2", 64'(chk_hit_o), 64'b11);
        chk("byp_val1_c2", chk_value_o[1], 64'h200);
        cyc();
        smp();
        chk("byp_hit_c3", 64'(chk_hit_o), 64'b01);
        chk("byp_val0_c3", chk_value_o[0], 64'h1234);
        chk("byp_val1_c3", chk_value_o[1], 64'h0);
        cyc();
        smp();
        chk("byp_hit_c4", 64'(chk_hit_o), 64'b00);
        chk("byp_val0_c4", chk_value_o[0], 64'h0);
        chk_idx_i = '0;

        // Back-to-back single requester
        cyc();
        drive(0, 5'd5, 64'hA); push(5'd5, 64'hA);
        smp(); chk("b2b_ready0", 64'(req_ready_o[0]), 64'd1);
        cyc();
        drive(0, 5'd6, 64'hB); push(5'd6, 64'hB);
        smp(); chk("b2b_ready1", 64'(req_ready_o[0]), 64'd1);
        cyc();
        drive(0, 5'd7, 64'hC); push(5'd7, 64'hC);
        smp(); chk("b2b_ready2", 64'(req_ready_o[0]), 64'd1);
        cyc(); req_valid_i = '0;
        smp(); chk("b2b_last_valid", 64'(rf_valid_o), 64'd1);
        cyc();
        smp(); chk("b2b_idle", 64'(rf_valid_o), 64'd0);

        // Reset while two slots are full: the buffered writes vanish
        cyc();
        drive(0, 5'd20, 64'h2020); drive(1, 5'd21, 64'h2121);
        chk_idx_i[0] = 5'd20;
        smp(); chk("rstmid_hit_pre", 64'(chk_hit_o[0]), 64'd0);
        cyc();
        req_valid_i = '0;
        rst_n_i     = 1'b0;
        smp();
        chk("rstmid_rf_valid", 64'(rf_valid_o), 64'd0);
        chk("rstmid_ready", 64'(req_ready_o), 64'b111);
        chk("rstmid_hit", 64'(chk_hit_o), 64'd0);
        chk("rstmid_rf_idx", 64'(rf_rd_idx_o), 64'd0);
        chk("rstmid_rf_value", rf_rd_value_o, 64'd0);
        cyc(); cyc();
        rst_n_i = 1'b1;
        smp(); chk("rstmid_after_valid", 64'(rf_valid_o), 64'd0);
        cyc();
        smp(); chk("rstmid_after_valid2", 64'(rf_valid_o), 64'd0);

        // Pointer is back at 0 after reset: order must be req0, req1, req2
        cyc();
        drive(0, 5'd1, 64'h44); drive(1, 5'd2, 64'h55); drive(2, 5'd3, 64'h66);
        push(5'd1, 64'h44); push(5'd2, 64'h55); push(5'd3, 64'h66);
        cyc(); req_valid_i = '0;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
        cyc();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
